// File: rtl/pattern_loader_pkg.sv
// pattern_loader shared definitions: opcodes, responses,
// FSM encoding and word/address widths.
package pattern_loader_pkg;

  localparam logic [7:0] OP_MODE  = 8'h50;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_LEDS  = 8'h4C;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  localparam int LED_WORD_W = 72;
  localparam int PAT_ADDR_W = 8;

  localparam logic [7:0] MODE_MAX = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MODE = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  typedef enum logic {
    TGT_RAM  = 1'b0,
    TGT_LEDS = 1'b1
  } target_t;

endpackage

// File: rtl/pattern_loader_accum.sv
// pattern_loader_accum: MSB-first byte shift register and
// byte counter; done pulses with the last byte of a word.
module pattern_loader_accum
  import pattern_loader_pkg::*;
#(
  parameter int DATA_BYTES = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [7:0]            byte_in,
  output logic [LED_WORD_W-1:0] word,
  output logic                  done
);

  localparam int SW = (DATA_BYTES - 1) * 8;
  localparam int CW = $clog2(DATA_BYTES);

  // Only the first DATA_BYTES-1 bytes are stored; the last
  // byte is merged combinationally so the word is usable
  // in the same cycle the final byte arrives.
  logic [SW-1:0] shreg;
  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(DATA_BYTES - 1));
  assign done = shift && last;
  assign word = {shreg, byte_in};

  // Shift bytes in and count 0..DATA_BYTES-1, wrapping on done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= {shreg[SW-9:0], byte_in};
      cnt   <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_loader.sv
// pattern_loader: host command parser feeding the LED datapath.
// Optional inter-byte timeout: PATTERN_LOADER_TIMEOUT_EN.
module pattern_loader
  import pattern_loader_pkg::*;
#(
  parameter int DATA_BYTES     = 9,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [PAT_ADDR_W-1:0] pat_up_a,
  output logic [LED_WORD_W-1:0] pat_up_d,
  output logic                  pat_up_we,
  output logic [1:0]            pattern_type,
  output logic [LED_WORD_W-1:0] leds_i
);

  state_t                  state;
  target_t                 target;
  logic [PAT_ADDR_W-1:0]   addr;
  logic                    acc_shift;
  logic                    acc_done;
  logic [LED_WORD_W-1:0]   acc_word;
  logic                    tmo_hit;

  assign acc_shift = rx_valid && (state == ST_DATA);

  pattern_loader_accum #(
    .DATA_BYTES(DATA_BYTES)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_hit),
    .shift  (acc_shift),
    .byte_in(rx_data),
    .word   (acc_word),
    .done   (acc_done)
  );

`ifdef PATTERN_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  // A received byte always wins over expiry in the same cycle.
  assign tmo_hit = !rx_valid && (state != ST_IDLE) &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Count idle cycles while a command is partially received.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (rx_valid || (state == ST_IDLE) || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // Command FSM with registered RAM, LED, mode and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      target       <= TGT_RAM;
      addr         <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      pat_up_a     <= '0;
      pat_up_d     <= '0;
      pat_up_we    <= 1'b0;
      pattern_type <= '0;
      leds_i       <= '0;
    end else begin
      pat_up_we <= 1'b0;
      if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (rx_valid) begin
        unique case (state)
          ST_IDLE: begin
            if (rx_data == OP_MODE) begin
              state <= ST_MODE;
            end else if (rx_data == OP_WRITE) begin
              state <= ST_ADDR;
            end else if (rx_data == OP_LEDS) begin
              state  <= ST_DATA;
              target <= TGT_LEDS;
            end else begin
              tx_data  <= RSP_NAK;
              tx_valid <= 1'b1;
            end
          end
          ST_MODE: begin
            state    <= ST_IDLE;
            tx_valid <= 1'b1;
            if (rx_data <= MODE_MAX) begin
              pattern_type <= rx_data[1:0];
              tx_data      <= RSP_ACK;
            end else begin
              tx_data <= RSP_NAK;
            end
          end
          ST_ADDR: begin
            addr   <= rx_data;
            target <= TGT_RAM;
            state  <= ST_DATA;
          end
          ST_DATA: begin
            if (acc_done) begin
              state    <= ST_IDLE;
              tx_data  <= RSP_ACK;
              tx_valid <= 1'b1;
              if (target == TGT_RAM) begin
                pat_up_a  <= addr;
                pat_up_d  <= acc_word;
                pat_up_we <= 1'b1;
              end else begin
                leds_i <= acc_word;
              end
            end
          end
        endcase
      end else if (tmo_hit) begin
        state    <= ST_IDLE;
        tx_data  <= RSP_NAK;
        tx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_loader.sv
// tb_pattern_loader: directed and randomized command checks
// against a command-level reference model.
module tb_pattern_loader;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
`ifdef PATTERN_LOADER_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 250000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  pat_up_a;
  logic [71:0] pat_up_d;
  logic        pat_up_we;
  logic [1:0]  pattern_type;
  logic [71:0] leds_i;

  pattern_loader #(
    .DATA_BYTES    (9),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .pat_up_a    (pat_up_a),
    .pat_up_d    (pat_up_d),
    .pat_up_we   (pat_up_we),
    .pattern_type(pattern_type),
    .leds_i      (leds_i)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Observed RAM writes
  int          wr_cnt = 0;
  logic [7:0]  wr_a = '0;
  logic [71:0] wr_d = '0;

  always @(posedge clk) begin
    #1;
    if (pat_up_we) begin
      wr_cnt++;
      wr_a = pat_up_a;
      wr_d = pat_up_d;
    end
  end

  // Reference model state
  logic [1:0]  exp_type = '0;
  logic [71:0] exp_leds = '0;
  logic [7:0]  exp_rsp = '0;
  int          exp_wr = 0;
  logic [7:0]  exp_a = '0;
  logic [71:0] exp_d = '0;

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
  endtask

  task automatic send_word(input logic [71:0] d, input int first,
                           input int last);
    for (int i = first; i <= last; i++) send(d[71-8*i -: 8]);
  endtask

  task automatic cmd_mode(input logic [7:0] m);
    send(8'h50);
    send(m);
    if (m <= 8'd3) begin
      exp_type = m[1:0];
      exp_rsp  = ACK;
    end else begin
      exp_rsp = NAK;
    end
  endtask

  task automatic cmd_write(input logic [7:0] a, input logic [71:0] d);
    send(8'h57);
    send(a);
    send_word(d, 0, 8);
    exp_wr++;
    exp_a   = a;
    exp_d   = d;
    exp_rsp = ACK;
  endtask

  task automatic cmd_leds(input logic [71:0] d);
    send(8'h4C);
    send_word(d, 0, 8);
    exp_leds = d;
    exp_rsp  = ACK;
  endtask

  task automatic cmd_junk(input logic [7:0] b);
    send(b);
    exp_rsp = NAK;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tx_valid"}, tx_valid, 1'b1);
    chk({tag, ".tx_data"}, tx_data, exp_rsp);
    chk({tag, ".type"}, pattern_type, exp_type);
    chk({tag, ".leds"}, leds_i, exp_leds);
    chk({tag, ".wr_cnt"}, wr_cnt, exp_wr);
    chk({tag, ".wr_a"}, wr_a, exp_a);
    chk({tag, ".wr_d"}, wr_d, exp_d);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".tx_valid"}, tx_valid, 1'b0);
    chk({tag, ".tx_data"}, tx_data, 8'h00);
    chk({tag, ".pat_a"}, pat_up_a, 8'h00);
    chk({tag, ".pat_d"}, pat_up_d, 72'h0);
    chk({tag, ".we"}, pat_up_we, 1'b0);
    chk({tag, ".type"}, pattern_type, 2'd0);
    chk({tag, ".leds"}, leds_i, 72'h0);
  endtask

  function automatic logic [71:0] rand_word();
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[8*i +: 8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  function automatic logic [7:0] rand_junk();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255));
    while (b == 8'h50 || b == 8'h57 || b == 8'h4C);
    return b;
  endfunction

  logic [71:0] w;
  int          kind;

  initial begin
    rst      = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    cmd_mode(8'h02);
    check_all("mode2");
    @(negedge clk);
    chk("mode2.clear", tx_valid, 1'b0);

    cmd_write(8'h10, 72'h010203040506070809);
    check_all("write10");

    cmd_leds({9{8'hFF}});
    check_all("ledsff");
    cmd_mode(8'h07);
    check_all("mode7");

    tx_ready = 1'b0;
    cmd_junk(8'hAA);
    check_all("junkAA");
    cmd_mode(8'h01);
    check_all("overwrite");
    tx_ready = 1'b1;
    @(negedge clk);
    chk("overwrite.clear", tx_valid, 1'b0);
    chk("overwrite.hold", tx_data, ACK);

    send(8'h57);
    send(8'h20);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    #2 rst = 1'b1;
    exp_type = '0;
    exp_leds = '0;
    @(negedge clk);
    check_reset("midreset");
    rst = 1'b0;
    cmd_write(8'h21, rand_word());
    check_all("write21");

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: cmd_mode(8'($urandom_range(0, 7)));
        1: cmd_write(8'($urandom_range(0, 255)), rand_word());
        2: cmd_leds(rand_word());
        default: cmd_junk(rand_junk());
      endcase
      check_all($sformatf("rand%0d", n));
    end

    @(negedge clk);
    w = rand_word();
    send(8'h4C);
    send_word(w, 0, 3);
    repeat (100) @(negedge clk);
`ifdef PATTERN_LOADER_TIMEOUT_EN
    exp_rsp = NAK;
    check_all("timeout");
    cmd_mode(8'h03);
    check_all("after_tmo");
`else
    chk("notimeout.tx_valid", tx_valid, 1'b0);
    chk("notimeout.leds", leds_i, exp_leds);
    send_word(w, 4, 8);
    exp_leds = w;
    exp_rsp  = ACK;
    check_all("late_done");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
